// File: rtl/serial_link_host.sv
// serial_link_host: host end of the single-wire test link.
// Frames 32-bit words onto tx_line, deserialises echoed words from rx_line
// and checks each echo against an in-order FIFO of the words sent.
module serial_link_host #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [31:0]                   tx_data,
    output logic                          tx_ready,
    output logic                          tx_line,
    input  logic                          rx_line,
    output logic                          rx_valid,
    output logic [31:0]                   rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic [CNT_W-1:0]              match_cnt,
    output logic [7:0]                    err_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_GUARD = 2'd3;

    localparam logic [1:0] RX_HUNT  = 2'd0;
    localparam logic [1:0] RX_SHIFT = 2'd1;
    localparam logic [1:0] RX_DONE  = 2'd2;

    logic [1:0]    tx_state;
    logic [31:0]   tx_shift;
    logic [4:0]    tx_bit;
    logic [1:0]    rx_state;
    logic [31:0]   rx_shift;
    logic [4:0]    rx_bit;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pending    = count;

    // Ready only in IDLE/GUARD with room; forced low while reset is held.
    // Uses pre-pop occupancy, so a pop at full never enables a push that cycle.
    assign tx_ready = !rst && !fifo_full &&
                      ((tx_state == TX_IDLE) || (tx_state == TX_GUARD));
    assign push     = tx_valid && tx_ready;
    assign rx_valid = (rx_state == RX_DONE);
    assign pop      = rx_valid && !fifo_empty;

    // Serial output is decoded from state so reset drops it immediately
    always_comb begin
        tx_line = 1'b0;
        case (tx_state)
            TX_START: tx_line = 1'b1;
            TX_DATA:  tx_line = tx_shift[31];
            default:  tx_line = 1'b0;
        endcase
    end

    // TX framing FSM: start bit, 32 data bits MSB first, guard bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE, TX_GUARD: begin
                    if (push) begin
                        tx_shift <= tx_data;
                        tx_state <= TX_START;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                end
                TX_START: begin
                    tx_bit   <= '0;
                    tx_state <= TX_DATA;
                end
                default: begin
                    tx_shift <= {tx_shift[30:0], 1'b0};
                    tx_bit   <= tx_bit + 5'd1;
                    if (tx_bit == 5'd31) tx_state <= TX_GUARD;
                end
            endcase
        end
    end

    // RX deframing FSM; rx_data loads on the last bit so it is valid in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_HUNT;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_data  <= '0;
        end else begin
            case (rx_state)
                RX_HUNT: begin
                    rx_bit <= '0;
                    if (rx_line) rx_state <= RX_SHIFT;
                end
                RX_SHIFT: begin
                    rx_shift <= {rx_shift[30:0], rx_line};
                    rx_bit   <= rx_bit + 5'd1;
                    if (rx_bit == 5'd31) begin
                        rx_data  <= {rx_shift[30:0], rx_line};
                        rx_state <= RX_DONE;
                    end
                end
                default: rx_state <= RX_HUNT;
            endcase
        end
    end

    // Expected-word storage; contents need no reset, pointers qualify them
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Echo checker: compare against FIFO head, unsolicited words are errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            err_cnt   <= '0;
        end else if (rx_valid) begin
            if (!fifo_empty && (rx_data == mem[rd_ptr])) begin
                if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            end else begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_link_host.sv
// Bench for serial_link_host: scoreboard of expected rx words plus
// per-scenario tasks covering loopback, backpressure, errors, reset, saturation.
module tb_serial_link_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_ready;
    logic        tx_line;
    logic        rx_line;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic [2:0]  pending;
    logic [15:0] match_cnt;
    logic [7:0]  err_cnt;

    logic        loop_en = 1'b0;
    logic        rx_drv  = 1'b0;
    logic [2:0]  dly;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    serial_link_host #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_line(tx_line), .rx_line(rx_line),
        .rx_valid(rx_valid), .rx_data(rx_data), .pending(pending),
        .match_cnt(match_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // 3-cycle loopback delay, cleared with the DUT so no stale bits replay
    always @(posedge clk or posedge rst) begin
        if (rst) dly <= '0;
        else     dly <= {dly[1:0], tx_line};
    end
    assign rx_line = loop_en ? dly[2] : rx_drv;

    // Scoreboard: every rx_valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (rx_valid) begin
            logic [31:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected got=%08h expected=none", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    failures++;
                    $display("FAIL rx_data got=%08h expected=%08h", rx_data, e);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; tx_valid = 1'b0; rx_drv = 1'b0; loop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive one frame on rx_line: start in cycle M, bits M+1..M+32, guard M+33
    task automatic send_rx(input logic [31:0] w);
        @(posedge clk); #1 rx_drv = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            @(posedge clk); #1 rx_drv = w[i];
        end
        @(posedge clk); #1 rx_drv = 1'b0;
    endtask

    // Offer one word and wait (bounded) for acceptance
    task automatic send_tx(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        tx_data = w; tx_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (tx_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (tx_line !== 1'b0)   begin failures++; $display("FAIL rst_tx_line got=%b expected=0", tx_line); end
        checks++; if (tx_ready !== 1'b0)  begin failures++; $display("FAIL rst_tx_ready got=%b expected=0", tx_ready); end
        checks++; if (rx_valid !== 1'b0)  begin failures++; $display("FAIL rst_rx_valid got=%b expected=0", rx_valid); end
        checks++; if (rx_data !== 32'h0)  begin failures++; $display("FAIL rst_rx_data got=%08h expected=0", rx_data); end
        checks++; if (pending !== 3'd0)   begin failures++; $display("FAIL rst_pending got=%0d expected=0", pending); end
        checks++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL rst_match got=%0d expected=0", match_cnt); end
        checks++; if (err_cnt !== 8'd0)   begin failures++; $display("FAIL rst_err got=%0d expected=0", err_cnt); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx_ready !== 1'b1)  begin failures++; $display("FAIL rst_release_ready got=%b expected=1", tx_ready); end
    endtask

    task automatic test_loopback();
        logic [31:0] w = 32'hA5A50F0F;
        int  c = 0;
        int  seen = -1;
        bit  bits_ok = 1'b1;
        do_reset();
        loop_en = 1'b1;
        @(posedge clk); #1;
        tx_data = w; tx_valid = 1'b1;       // cycle N
        exp_q.push_back(w);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL lb_ready got=%b expected=1", tx_ready); end
        while (seen < 0 && c < 60) begin
            @(posedge clk); #1; c++;
            tx_valid = 1'b0;
            if (c == 1) begin
                checks++; if (tx_line !== 1'b1) begin failures++; $display("FAIL lb_start got=%b expected=1", tx_line); end
                checks++; if (pending !== 3'd1) begin failures++; $display("FAIL lb_pending1 got=%0d expected=1", pending); end
            end
            if (c >= 2 && c <= 33 && tx_line !== w[33-c]) bits_ok = 1'b0;
            if (c == 34) begin
                checks++; if (tx_line !== 1'b0 || tx_ready !== 1'b1) begin
                    failures++; $display("FAIL lb_guard line=%b ready=%b expected line=0 ready=1", tx_line, tx_ready); end
            end
            if (rx_valid) seen = c;
        end
        checks++; if (!bits_ok) begin failures++; $display("FAIL lb_tx_bits got=corrupt expected=%08h", w); end
        checks++; if (seen != 37) begin failures++; $display("FAIL lb_rx_latency got=%0d expected=37", seen); end
        @(posedge clk); #1;
        checks++; if (match_cnt !== 16'd1) begin failures++; $display("FAIL lb_match got=%0d expected=1", match_cnt); end
        checks++; if (err_cnt !== 8'd0)    begin failures++; $display("FAIL lb_err got=%0d expected=0", err_cnt); end
        checks++; if (pending !== 3'd0)    begin failures++; $display("FAIL lb_pending0 got=%0d expected=0", pending); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        int accepted = 0;
        bit stop = 1'b0;
        do_reset();
        @(posedge clk); #1;
        tx_valid = 1'b1;
        for (int i = 0; i < 5 && !stop; i++) begin
            bit got = 1'b0;
            tx_data = w[i];
            for (int k = 0; k < 200 && !got; k++) begin
                if (tx_ready) got = 1'b1;
                @(posedge clk); #1;
            end
            if (got) accepted++; else stop = 1'b1;
        end
        tx_valid = 1'b0;
        checks++; if (accepted != 4)    begin failures++; $display("FAIL bp_accepted got=%0d expected=4", accepted); end
        checks++; if (pending !== 3'd4) begin failures++; $display("FAIL bp_pending got=%0d expected=4", pending); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b expected=0", tx_ready); end
        exp_q.push_back(w[0]);
        send_rx(w[0]);
        @(posedge clk); #1;
        checks++; if (pending !== 3'd3)  begin failures++; $display("FAIL bp_pending3 got=%0d expected=3", pending); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b expected=1", tx_ready); end
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(w[i]);
            send_rx(w[i]);
        end
        @(posedge clk); #1;
        checks++; if (match_cnt !== 16'd4 || err_cnt !== 8'd0 || pending !== 3'd0) begin
            failures++; $display("FAIL bp_drain match=%0d err=%0d pending=%0d expected 4/0/0", match_cnt, err_cnt, pending); end
    endtask

    task automatic test_mismatch();
        bit ok;
        do_reset();
        @(posedge clk); #1;
        send_tx(32'h00000001, ok);
        checks++; if (!ok || pending !== 3'd1) begin failures++; $display("FAIL mm_accept ok=%b pending=%0d expected ok=1 pending=1", ok, pending); end
        exp_q.push_back(32'h80000001);
        send_rx(32'h80000001);
        @(posedge clk); #1;
        checks++; if (err_cnt !== 8'd1)    begin failures++; $display("FAIL mm_err got=%0d expected=1", err_cnt); end
        checks++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL mm_match got=%0d expected=0", match_cnt); end
        checks++; if (pending !== 3'd0)    begin failures++; $display("FAIL mm_pending got=%0d expected=0", pending); end
    endtask

    task automatic test_unsolicited();
        do_reset();
        exp_q.push_back(32'hFFFFFFFF);
        send_rx(32'hFFFFFFFF);
        @(posedge clk); #1;
        checks++; if (err_cnt !== 8'd1)        begin failures++; $display("FAIL us_err got=%0d expected=1", err_cnt); end
        checks++; if (pending !== 3'd0)        begin failures++; $display("FAIL us_pending got=%0d expected=0", pending); end
        checks++; if (rx_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL us_rx_data got=%08h expected=ffffffff", rx_data); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rxw = 32'h12345678;
        logic [31:0] lw  = 32'h3C3CC3C3;
        int  pulses = 0;
        bit  seen = 1'b0;
        do_reset();
        @(posedge clk); #1;
        tx_data = 32'hFFFFFFFF; tx_valid = 1'b1;    // accepted at next edge
        @(posedge clk); #1;
        tx_valid = 1'b0; rx_drv = 1'b1;             // tx start bit, rx start bit
        for (int i = 31; i >= 22; i--) begin
            @(posedge clk); #1 rx_drv = rxw[i];
        end
        checks++; if (tx_line !== 1'b1) begin failures++; $display("FAIL rm_pre_line got=%b expected=1", tx_line); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx_line !== 1'b0) begin failures++; $display("FAIL rm_line_drop got=%b expected=0", tx_line); end
        rx_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (rx_valid) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rm_no_rx_valid got=%0d expected=0", pulses); end
        checks++; if (match_cnt !== 16'd0 || err_cnt !== 8'd0 || pending !== 3'd0) begin
            failures++; $display("FAIL rm_cleared match=%0d err=%0d pending=%0d expected 0/0/0", match_cnt, err_cnt, pending); end
        loop_en = 1'b1;
        exp_q.push_back(lw);
        tx_data = lw; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk); #1;
            if (rx_valid) seen = 1'b1;
        end
        @(posedge clk); #1;
        checks++; if (!seen || match_cnt !== 16'd1) begin
            failures++; $display("FAIL rm_fresh_loop seen=%b match=%0d expected seen=1 match=1", seen, match_cnt); end
        loop_en = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            logic [31:0] v = 32'hC0DE0000 | 32'(i);
            exp_q.push_back(v);
            send_rx(v);
            if (i == 254) begin
                @(posedge clk); #1;
                checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_at255 got=%0d expected=255", err_cnt); end
            end
        end
        @(posedge clk); #1;
        checks++; if (err_cnt !== 8'd255)  begin failures++; $display("FAIL sat_hold got=%0d expected=255", err_cnt); end
        checks++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL sat_match got=%0d expected=0", match_cnt); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_backpressure();
        test_mismatch();
        test_unsolicited();
        test_reset_midframe();
        test_saturation();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d expected=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_link_host.md
# serial_link_host

Host-side end of the single-wire test link. It frames 32-bit test words onto the serial line that feeds the chip's deserializer. It also captures the echoed 32-bit words arriving from the chip's serializer and checks each one against the word that was sent. It sits in the tester/bench harness, running at the fast line clock. It gives the self-test flow a pass/fail tally without software post-processing.

## Interface
Parameters:
- FIFO_DEPTH, 4: outstanding expected words; must be a power of 2, minimum 2.
- CNT_W, 16: width of match_cnt.

Ports:
- clk  in  1  line clock; one serial bit per cycle.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  host offers tx_data.
- tx_data  in  32  word to transmit.
- tx_ready  out  1  block accepts tx_data this cycle.
- tx_line  out  1  serial output to the chip's data input.
- rx_line  in  1  serial input from the chip's data output.
- rx_valid  out  1  one-cycle pulse; rx_data holds a received word.
- rx_data  out  32  last received word.
- pending  out  log2(FIFO_DEPTH)+1  expected words not yet echoed.
- match_cnt  out  CNT_W  saturating count of correct echoes.
- err_cnt  out  8  saturating count of mismatches plus unsolicited words.

## Operation
- Frame format, both directions:
  - Line idles 0.
  - One start bit of 1.
  - 32 data bits, MSB first.
  - At least one idle 0 (guard bit) before the next start bit.
- TX FSM:
  - IDLE: tx_ready = !fifo_full.
  - On tx_valid & tx_ready: latch tx_data into the shift register, push it into the expected FIFO, go to START.
  - START: tx_line = 1 → DATA.
  - DATA: 32 cycles, tx_line = shift[31], shift left; bit counter 0..31 → GUARD.
  - GUARD: tx_line = 0, tx_ready = !fifo_full. An accept here returns to START; otherwise → IDLE.
  - tx_ready is 0 in START and DATA.
- RX FSM:
  - HUNT: rx_line sampled 1 → SHIFT.
  - SHIFT: sample rx_line on 32 consecutive cycles into rx_shift (shift left, LSB in) → DONE.
  - DONE: one cycle; rx_data <= rx_shift, rx_valid = 1; → HUNT. A start bit is not recognised in DONE; the sender's guard bit covers this cycle.
- Checker, on each DONE cycle:
  - FIFO non-empty: pop the head. Equal → match_cnt+1; unequal → err_cnt+1.
  - FIFO empty: err_cnt+1 (unsolicited word); no pop.
  - Both counters saturate at all-ones and never wrap.
- FIFO:
  - Circular buffer with wrap-around read/write pointers; pending = occupancy.
  - Push and pop in the same cycle leave pending unchanged.
  - Push while full cannot occur, because tx_ready gates it. tx_ready is evaluated from the pre-pop occupancy, so a simultaneous pop at full does not enable a push that cycle.

## Timing
- Reset values: tx_line 0, tx_ready 0 while rst high and 1 from the first cycle after release, rx_valid 0, rx_data 0, pending 0, match_cnt 0, err_cnt 0. Both FSMs reset to IDLE/HUNT.
- Accept in cycle N:
  - tx_line = 1 in cycle N+1.
  - tx_data[31] in N+2, tx_data[0] in N+33.
  - Guard in N+34.
  - Earliest next accept N+34, earliest next start bit N+35. The back-to-back frame period is 34 cycles.
- pending increments in cycle N+1, i.e. it is registered.
- RX: start bit sampled in cycle M; data bit 31 in M+1, bit 0 in M+32; rx_valid and rx_data in M+33. Counters and pending update in M+34.
- Reset mid-frame: all state clears asynchronously and tx_line drops to 0 immediately. A partially received frame is discarded with no rx_valid; the counters clear.
- rx_line is assumed synchronous to clk; no internal synchroniser.

## Test plan
- Loopback: tx_line wired to rx_line through a 3-cycle delay; send 0xA5A50F0F → tx_line start at N+1, rx_valid at N+37 with rx_data 0xA5A50F0F, match_cnt 1, err_cnt 0, pending returns 0.
- Backpressure: no loopback, tx_valid held high with 5 words → 4 accepted, tx_ready stays 0 after the 4th frame, pending 4. Then inject one correct echo → pending 3 and tx_ready returns 1.
- Mismatch: send 0x00000001 and drive an rx frame carrying 0x80000001 → rx_valid, err_cnt 1, match_cnt 0, pending 0.
- Unsolicited: with pending 0, drive an rx frame of 0xFFFFFFFF → err_cnt 1, pending stays 0, rx_data 0xFFFFFFFF.
- Reset mid-frame: assert rst at bit 10 of both a TX and an RX frame → tx_line 0 the same cycle, no rx_valid, all counters 0. After release, a fresh loopback word passes with match_cnt 1.
- Saturation: force 260 mismatching echoes → err_cnt stops at 255.
